// File: rtl/debug_conf_wb_master.sv
// Wishbone classic single-access master bridging the debug processor's register
// request port to the NA configuration slave, with retry, backoff and timeout.
module debug_conf_wb_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int unsigned MAX_RETRY = 4,
   parameter int unsigned RETRY_GAP = 2,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_status,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_cab_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,
   input  logic [31:0] wbm_dat_i
);

   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_ERR     = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_RETRY   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_BACKOFF,
      S_RESP
   } state_t;

   state_t         state;
   logic [RW-1:0]  retry_cnt;
   logic [GW-1:0]  gap_cnt;
   logic [TW-1:0]  timeout_cnt;

   assign wbm_sel_o = 4'hf;
   assign wbm_cab_o = 1'b0;
   assign wbm_cti_o = 3'b000;
   assign wbm_bte_o = 2'b00;

   // Access sequencer; every bus and response output is registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_data    <= 32'h0;
         rsp_status  <= ST_OK;
         wbm_adr_o   <= 32'h0;
         wbm_dat_o   <= 32'h0;
         wbm_we_o    <= 1'b0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         retry_cnt   <= RW'(0);
         gap_cnt     <= GW'(0);
         timeout_cnt <= TW'(0);
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  wbm_we_o  <= req_we;
                  wbm_adr_o <= BASE_ADDR | {16'h0, req_addr};
                  wbm_dat_o <= req_data;
                  retry_cnt <= RW'(0);
                  // Misaligned word accesses are refused without touching the bus.
                  if (req_addr[1:0] != 2'b00) begin
                     state      <= S_RESP;
                     rsp_valid  <= 1'b1;
                     rsp_status <= ST_ERR;
                     rsp_data   <= 32'h0;
                  end else begin
                     state       <= S_BUS;
                     wbm_cyc_o   <= 1'b1;
                     wbm_stb_o   <= 1'b1;
                     timeout_cnt <= TW'(0);
                  end
               end
            end

            S_BUS: begin
               timeout_cnt <= timeout_cnt + TW'(1);
               if (wbm_err_i) begin
                  state      <= S_RESP;
                  wbm_cyc_o  <= 1'b0;
                  wbm_stb_o  <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_ERR;
                  rsp_data   <= 32'h0;
               end else if (wbm_ack_i) begin
                  state      <= S_RESP;
                  wbm_cyc_o  <= 1'b0;
                  wbm_stb_o  <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_OK;
                  rsp_data   <= wbm_we_o ? 32'h0 : wbm_dat_i;
               end else if (wbm_rty_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  if (retry_cnt < RW'(MAX_RETRY)) begin
                     state     <= S_BACKOFF;
                     retry_cnt <= retry_cnt + RW'(1);
                     gap_cnt   <= GW'(0);
                  end else begin
                     state      <= S_RESP;
                     rsp_valid  <= 1'b1;
                     rsp_status <= ST_RETRY;
                     rsp_data   <= 32'h0;
                  end
               end else if ((TIMEOUT != 0) && (timeout_cnt == TW'(TIMEOUT - 1))) begin
                  state      <= S_RESP;
                  wbm_cyc_o  <= 1'b0;
                  wbm_stb_o  <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_TIMEOUT;
                  rsp_data   <= 32'h0;
               end
            end

            S_BACKOFF: begin
               if (gap_cnt == GW'(RETRY_GAP - 1)) begin
                  state       <= S_BUS;
                  wbm_cyc_o   <= 1'b1;
                  wbm_stb_o   <= 1'b1;
                  timeout_cnt <= TW'(0);
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end

            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               wbm_cyc_o <= 1'b0;
               wbm_stb_o <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_conf_wb_master.sv
// Bench for debug_conf_wb_master: scripted Wishbone slave, directed scenarios and
// random transactions checked against an outcome/latency model.
module tb_debug_conf_wb_master;

   localparam int unsigned MAXR = 4;
   localparam int unsigned GAP  = 2;
   localparam int unsigned TMO  = 8;
   localparam logic [31:0] BASE = 32'hA5A5_0000;

   localparam int K_ACK = 0;
   localparam int K_ERR = 1;
   localparam int K_RTY = 2;
   localparam int K_SIL = 3;
   localparam int K_AE  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = 16'h0;
   logic [31:0] req_data = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_status;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_cab_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_err_i = 1'b0;
   logic        wbm_rty_i = 1'b0;
   logic [31:0] wbm_dat_i = 32'h0;

   always #5 clk = ~clk;

   debug_conf_wb_master #(
      .BASE_ADDR (BASE),
      .MAX_RETRY (MAXR),
      .RETRY_GAP (GAP),
      .TIMEOUT   (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_status (rsp_status),
      .wbm_adr_o  (wbm_adr_o),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_sel_o  (wbm_sel_o),
      .wbm_we_o   (wbm_we_o),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_cab_o  (wbm_cab_o),
      .wbm_cti_o  (wbm_cti_o),
      .wbm_bte_o  (wbm_bte_o),
      .wbm_ack_i  (wbm_ack_i),
      .wbm_err_i  (wbm_err_i),
      .wbm_rty_i  (wbm_rty_i),
      .wbm_dat_i  (wbm_dat_i)
   );

   int tests = 0;
   int fails = 0;

   // Per-attempt slave script for the current transaction.
   int          att_kind [8];
   int          att_dly  [8];
   logic [31:0] att_rd   [8];
   int          att_base = 0;

   int          att_cnt = 0;
   int          stb_len = 0;
   int          gap_len = 0;
   int          pulses_all = 0;
   int          stb_all = 0;
   int          gap_bad_all = 0;
   logic [31:0] cap_adr = 32'h0;
   logic [31:0] cap_dat = 32'h0;
   logic        cap_we = 1'b0;
   logic [3:0]  cap_sel = 4'h0;

   // Slave and bus monitor: terminates per script while stb is high, drives junk otherwise.
   always @(negedge clk) begin
      int a;
      a = att_cnt - att_base;
      if (a > 7) a = 7;
      if (a < 0) a = 0;
      if (wbm_stb_o) begin
         if (stb_len == 0) begin
            pulses_all++;
            if (att_cnt != att_base && gap_len != GAP) gap_bad_all++;
            cap_adr = wbm_adr_o;
            cap_dat = wbm_dat_o;
            cap_we  = wbm_we_o;
            cap_sel = wbm_sel_o;
         end
         wbm_ack_i = 1'b0;
         wbm_err_i = 1'b0;
         wbm_rty_i = 1'b0;
         wbm_dat_i = $urandom;
         if (att_kind[a] != K_SIL && stb_len == att_dly[a]) begin
            case (att_kind[a])
               K_ACK: begin wbm_ack_i = 1'b1; wbm_dat_i = att_rd[a]; end
               K_ERR: wbm_err_i = 1'b1;
               K_RTY: wbm_rty_i = 1'b1;
               K_AE:  begin wbm_ack_i = 1'b1; wbm_err_i = 1'b1; end
               default: ;
            endcase
         end
         stb_len++;
         stb_all++;
         gap_len = 0;
      end else begin
         wbm_ack_i = 1'($urandom);
         wbm_err_i = 1'($urandom);
         wbm_rty_i = 1'($urandom);
         wbm_dat_i = $urandom;
         if (stb_len > 0) begin
            att_cnt++;
            stb_len = 0;
         end
         gap_len++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outcome of a request from the slave script: status, data, latency, pulses, stb cycles.
   function automatic void model(input logic we, input logic [15:0] addr,
                                 output logic [1:0] st, output logic [31:0] d,
                                 output int lat, output int np, output int nstb);
      int retries;
      retries = 0;
      st = 2'd0; d = 32'h0; lat = 1; np = 0; nstb = 0;
      if (addr[1:0] != 2'b00) begin
         st = 2'd1;
         return;
      end
      for (int i = 0; i < 8; i++) begin
         int len;
         np++;
         if (att_kind[i] == K_SIL || att_dly[i] >= int'(TMO)) begin
            lat += TMO; nstb += TMO; st = 2'd2;
            return;
         end
         len = att_dly[i] + 1;
         lat += len; nstb += len;
         if (att_kind[i] == K_ERR || att_kind[i] == K_AE) begin st = 2'd1; return; end
         if (att_kind[i] == K_ACK) begin st = 2'd0; d = we ? 32'h0 : att_rd[i]; return; end
         if (retries == int'(MAXR)) begin st = 2'd3; return; end
         retries++;
         lat += GAP;
      end
   endfunction

   task automatic set_all(input int kind, input int dly);
      for (int i = 0; i < 8; i++) begin
         att_kind[i] = kind;
         att_dly[i]  = dly;
         att_rd[i]   = $urandom;
      end
   endtask

   task automatic run_txn(input logic we, input logic [15:0] addr, input logic [31:0] data,
                          input int hold);
      logic [1:0]  e_st;
      logic [31:0] e_d;
      int          e_lat, e_np, e_nstb, p0, s0, g0, lat;
      model(we, addr, e_st, e_d, e_lat, e_np, e_nstb);
      @(posedge clk); #1;
      att_base = att_cnt;
      p0 = pulses_all; s0 = stb_all; g0 = gap_bad_all;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_data  = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 100);
      chk("latency", 64'(lat), 64'(e_lat));
      chk("rsp_status", 64'(rsp_status), 64'(e_st));
      chk("rsp_data", 64'(rsp_data), 64'(e_d));
      chk("stb_pulses", 64'(pulses_all - p0), 64'(e_np));
      chk("stb_cycles", 64'(stb_all - s0), 64'(e_nstb));
      chk("retry_gap", 64'(gap_bad_all - g0), 64'd0);
      if (e_np > 0) begin
         chk("wb_adr", 64'(cap_adr), 64'(BASE | {16'h0, addr}));
         chk("wb_we_sel", 64'({cap_we, cap_sel}), 64'({we, 4'hf}));
         if (we) chk("wb_dat", 64'(cap_dat), 64'(data));
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("rsp_hold", 64'({rsp_valid, req_ready, rsp_status, rsp_data}),
             64'({1'b1, 1'b0, e_st, e_d}));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("rsp_release", 64'({rsp_valid, req_ready, wbm_cyc_o}), 64'({1'b0, 1'b1, 1'b0}));
   endtask

   initial begin
      set_all(K_ACK, 0);
      repeat (2) @(negedge clk);
      chk("rst_bus_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'd0);
      chk("rst_adr_dat", 64'({wbm_adr_o, wbm_dat_o}), 64'd0);
      chk("rst_rsp", 64'({rsp_valid, rsp_status, rsp_data}), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("const_outs", 64'({wbm_sel_o, wbm_cab_o, wbm_cti_o, wbm_bte_o}), 64'({4'hf, 1'b0, 3'b000, 2'b00}));
      @(posedge clk); #1;
      rst = 1'b1;

      // Read acked in the first strobe cycle.
      set_all(K_ACK, 0);
      att_rd[0] = 32'hCAFE_0001;
      run_txn(1'b0, 16'h0004, 32'h0, 0);

      // Write answered with err.
      set_all(K_ERR, 0);
      run_txn(1'b1, 16'h0010, 32'h5, 0);

      // Persistent retry exhausts after MAXR re-issues.
      set_all(K_RTY, 0);
      run_txn(1'b0, 16'h0020, 32'h0, 0);

      // Silent slave times out.
      set_all(K_SIL, 0);
      run_txn(1'b1, 16'h0024, 32'h1234_5678, 0);

      // Misaligned address, then simultaneous ack+err.
      set_all(K_ACK, 0);
      run_txn(1'b0, 16'h0003, 32'h0, 0);
      set_all(K_AE, 1);
      run_txn(1'b0, 16'h0008, 32'h0, 0);

      // Response back-pressure.
      set_all(K_ACK, 2);
      run_txn(1'b0, 16'h00FC, 32'h0, 5);

      // Reset asserted mid-access drops the cycle immediately.
      set_all(K_SIL, 0);
      @(posedge clk); #1;
      att_base = att_cnt;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_bus_stb", 64'({wbm_cyc_o, wbm_stb_o}), 64'({1'b1, 1'b1}));
      #2 rst = 1'b0;
      #1;
      chk("rst_async_drop", 64'({wbm_cyc_o, wbm_stb_o, rsp_valid, req_ready}),
          64'({1'b0, 1'b0, 1'b0, 1'b1}));
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_quiet", 64'({wbm_cyc_o, rsp_valid, req_ready}), 64'({1'b0, 1'b0, 1'b1}));
      end

      // Random transactions.
      for (int t = 0; t < 40; t++) begin
         logic        we;
         logic [15:0] addr;
         for (int i = 0; i < 8; i++) begin
            int r;
            r = int'($urandom % 10);
            if (r < 4)       att_kind[i] = K_ACK;
            else if (r == 4) att_kind[i] = K_ERR;
            else if (r < 8)  att_kind[i] = K_RTY;
            else if (r == 8) att_kind[i] = K_AE;
            else             att_kind[i] = K_SIL;
            att_dly[i] = ($urandom % 4 == 0) ? int'($urandom % 12) : int'($urandom % 3);
            att_rd[i]  = $urandom;
         end
         we   = 1'($urandom);
         addr = 16'($urandom);
         if ($urandom % 8 != 0) addr[1:0] = 2'b00;
         run_txn(we, addr, $urandom, int'($urandom % 4));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
